// File: rtl/ex3_accum.sv
// ex3_accum: digit-serial excess-3 decimal accumulator.
//
// Each accepted byte holds two excess-3 digits. They are added into a running
// two-digit excess-3 total, one digit per cycle (units then tens), with
// excess-3 carry correction. The total wraps modulo 100 and sets a sticky
// overflow flag when it does.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   clr        synchronous accumulator clear, honoured only in IDLE
//   in_valid   in_data valid
//   in_ready   block can accept in_data (IDLE and no clr)
//   in_data    operand, [7:4] tens, [3:0] units, excess-3
//   out_valid  result valid (DONE state)
//   out_ready  downstream accepts result
//   out_sum    accumulated total, excess-3
//   out_ovf    sticky wrap-past-99 flag
//   out_err    last accepted input held an invalid excess-3 digit
//
// Optional feature: define EX3_ERR_CHECK_EN to range-check input digits.
// Without it out_err is tied low and invalid codes go through the arithmetic.

module ex3_accum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_sum,
  output logic       out_ovf,
  output logic       out_err
);

  localparam logic [7:0] AccZero = 8'h33;

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  // Returns {cout, digit} for one excess-3 digit add.
  function automatic logic [4:0] digit_add(input logic [3:0] x, input logic [3:0] y,
                                           input logic cin);
    logic [4:0] raw;
    raw = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    if (raw[4]) begin
      digit_add = {1'b1, raw[3:0] + 4'd3};
    end else begin
      digit_add = {1'b0, raw[3:0] - 4'd3};
    end
  endfunction

  state_e     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic       ovf_q, ovf_d;
  logic [7:0] opnd_q, opnd_d;
  logic [3:0] units_q, units_d;
  logic       carry_q, carry_d;
  logic [4:0] units_sum, tens_sum;
  logic       upd_en;

`ifdef EX3_ERR_CHECK_EN
  function automatic logic digit_bad(input logic [3:0] d);
    return (d < 4'd3) || (d > 4'd12);
  endfunction

  logic err_q, err_d;
`endif

  assign units_sum = digit_add(acc_q[3:0], opnd_q[3:0], 1'b0);
  assign tens_sum  = digit_add(acc_q[7:4], opnd_q[7:4], carry_q);

`ifdef EX3_ERR_CHECK_EN
  // A flagged transaction still walks LO/HI/DONE but leaves acc/ovf alone.
  assign upd_en  = ~err_q;
  assign out_err = err_q;
`else
  assign upd_en  = 1'b1;
  assign out_err = 1'b0;
`endif

  assign in_ready  = (state_q == StIdle) && !clr;
  assign out_valid = (state_q == StDone);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    opnd_d  = opnd_q;
    units_d = units_q;
    carry_d = carry_q;
`ifdef EX3_ERR_CHECK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        // clr wins over in_valid; in_ready is already low while clr is high.
        if (clr) begin
          acc_d = AccZero;
          ovf_d = 1'b0;
`ifdef EX3_ERR_CHECK_EN
          err_d = 1'b0;
`endif
        end else if (in_valid) begin
          opnd_d  = in_data;
`ifdef EX3_ERR_CHECK_EN
          err_d   = digit_bad(in_data[7:4]) || digit_bad(in_data[3:0]);
`endif
          state_d = StLo;
        end
      end
      StLo: begin
        units_d = units_sum[3:0];
        carry_d = units_sum[4];
        state_d = StHi;
      end
      StHi: begin
        if (upd_en) begin
          acc_d = {tens_sum[3:0], units_q};
          if (tens_sum[4]) begin
            ovf_d = 1'b1;
          end
        end
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= AccZero;
      ovf_q   <= 1'b0;
      opnd_q  <= 8'h00;
      units_q <= 4'h0;
      carry_q <= 1'b0;
`ifdef EX3_ERR_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      opnd_q  <= opnd_d;
      units_q <= units_d;
      carry_q <= carry_d;
`ifdef EX3_ERR_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_ex3_accum.sv
// Self-checking bench for ex3_accum. Expected results come from a decimal
// model, are queued at accept time and compared when the DUT presents them.

module tb_ex3_accum;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_ovf;
  logic       out_err;

  int n_chk;
  int n_bad;

  // Expected entries: {err, ovf, sum}.
  logic [9:0] exp_q[$];

  // Decimal model state.
  int   acc_dec;
  logic ovf_m;

  ex3_accum u_dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] enc(input int v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(v / 10 + 3);
    u = 4'(v % 10 + 3);
    return {t, u};
  endfunction

  // Scoreboard monitor: one result per out_valid & out_ready cycle.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("sum", 32'(out_sum), 32'(e[7:0]));
        chk("ovf", 32'(out_ovf), 32'(e[8]));
        chk("err", 32'(out_err), 32'(e[9]));
      end
    end
  end

  // Drive one operand; expected value from the decimal model unless ovr is set.
  task automatic send(input logic [7:0] d, input bit ovr, input logic [9:0] ovr_exp);
    int k;
    logic [9:0] e;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (ovr) begin
      e = ovr_exp;
    end else begin
      acc_dec = acc_dec + (int'(d[7:4]) - 3) * 10 + (int'(d[3:0]) - 3);
      if (acc_dec >= 100) begin
        acc_dec = acc_dec - 100;
        ovf_m   = 1'b1;
      end
      e = {1'b0, ovf_m, enc(acc_dec)};
    end
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat_n0", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_n1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_n2", 32'(out_valid), 32'd1);
    chk("no_ready_in_done", 32'(in_ready), 32'd0);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    #1;
    chk("clr_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("clr_sum", 32'(out_sum), 32'h33);
    chk("clr_ovf", 32'(out_ovf), 32'd0);
    chk("clr_err", 32'(out_err), 32'd0);
    acc_dec = 0;
    ovf_m   = 1'b0;
  endtask

  initial begin
    logic [7:0] hold_sum;
    logic       hold_ovf;
    int         k;
    n_chk     = 0;
    n_bad     = 0;
    acc_dec   = 0;
    ovf_m     = 1'b0;
    rst       = 1'b1;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(out_sum), 32'h33);
    chk("rst_ovf", 32'(out_ovf), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);

    // Reset while the transaction sits in HI; nothing may come out of it.
    in_valid = 1'b1;
    in_data  = 8'h83;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
    end
    rst = 1'b0;
    chk("midrst_sum", 32'(out_sum), 32'h33);
    chk("midrst_ovf", 32'(out_ovf), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("midrst_quiet", 32'(out_valid), 32'd0);
    end

    // Simple add, units carry, overflow and wrap.
    send(8'h83, 1'b0, 10'h0);
    do_clr();
    send(8'h3C, 1'b0, 10'h0);
    send(8'h34, 1'b0, 10'h0);
    do_clr();
    send(8'h83, 1'b0, 10'h0);
    send(8'h83, 1'b0, 10'h0);
    send(8'h34, 1'b0, 10'h0);
    do_clr();

    // Backpressure: hold DONE for 5 cycles with in_valid pulses.
    out_ready = 1'b0;
    send(8'h45, 1'b0, 10'h0);
    hold_sum = out_sum;
    hold_ovf = out_ovf;
    chk("bp_sum_value", 32'(hold_sum), 32'(enc(acc_dec)));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = i[0];
      in_data  = 8'h99;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_sum", 32'(out_sum), 32'(hold_sum));
      chk("bp_ovf", 32'(out_ovf), 32'(hold_ovf));
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_still_done", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("bp_idle_ready", 32'(in_ready), 32'd1);
    chk("bp_idle_valid", 32'(out_valid), 32'd0);
    chk("bp_sum_kept", 32'(out_sum), 32'(hold_sum));

    // Invalid code 8'h3F from zero, then a valid follow-up.
    do_clr();
`ifdef EX3_ERR_CHECK_EN
    send(8'h3F, 1'b1, {1'b1, 1'b0, 8'h33});
    send(8'h34, 1'b1, {1'b0, 1'b0, 8'h34});
`else
    send(8'h3F, 1'b1, {1'b0, 1'b0, 8'h45});
    send(8'h34, 1'b1, {1'b0, 1'b0, 8'h46});
`endif

    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
